oisc8_div_ctrl: RTL and testbench
=================================

# oisc8_div_ctrl

Iterative 8-bit divide sequencer for the oisc8 ALU. It replaces the single-cycle combinational `/` and `%` behind the DIV/MOD port pair with a restoring shift-subtract engine. While the engine runs, it holds the program counter through a stall output. It sits beside the ALU block on the instruction bus: it takes the accumulator as dividend and the bus write to the DIV port as divisor and start strobe, and returns quotient and remainder to the DIV and DIVI reads.

## Interface
Parameters:
- `WIDTH`, default 8: operand, quotient and remainder width.
- `CNT_W`, default 3: iteration counter width; must satisfy 2^CNT_W >= WIDTH.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle strobe; bus write to the DIV port this cycle.
- `dividend`  in  WIDTH  accumulator value, sampled with `start`.
- `divisor`  in  WIDTH  bus data, sampled with `start`.
- `quotient`  out  WIDTH  registered quotient; drives the DIV read.
- `remainder`  out  WIDTH  registered remainder; drives the DIVI read.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse when results become valid.
- `div_zero`  out  1  sticky flag: last operation had divisor 0.
- `stall`  out  1  combinational; holds `pc`/`pcn` in the pc block.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + `start`: latch operands into internal registers. `r` (WIDTH+1 bits) = 0, `q` = `dividend`, `d` = `divisor`, `cnt` = WIDTH-1. Next state is RUN.
- IDLE + `start` + `divisor`==0: skip RUN and go to DONE. `quotient` = all-ones (8'hFF), `remainder` = `dividend`, `div_zero` = 1.
- RUN, each cycle:
  - `{r,q}` shift left by 1.
  - If shifted `r` >= `d`: `r` -= `d` and `q[0]` = 1.
  - `cnt` decrements.
  - On the step with `cnt`==0: write `quotient` = `q` and `remainder` = `r[WIDTH-1:0]`, then go to DONE.
- DONE: `done` = 1 for exactly one cycle. Next state is IDLE, or RUN if `start` is asserted (back-to-back accepted; same entry rules as IDLE).
- `start` in RUN is ignored. Operands are not re-latched and the count is not restarted. The bus/assembler must not issue this; the bench checks that it is ignored.
- `div_zero` updates only at operation acceptance: set for divisor 0, cleared otherwise.
- `quotient`/`remainder` hold their last values until the next operation completes. They never show partial results.
- `stall` = (`start` && state!=RUN) || state==RUN.
- Reset (any state, including mid-RUN):
  - State goes to IDLE; `quotient`, `remainder`, `busy`, `done`, `div_zero` and `cnt` go to 0.
  - The in-flight operation is discarded.
  - `stall` goes to 0 unless `start` is high.

## Timing
- Let T be the cycle in which `start` is high and accepted.
- Normal operation:
  - `stall` high in T..T+WIDTH, i.e. T..T+8.
  - `busy` high in T+1..T+8.
  - `done` high, with new results visible, in T+9.
  - `stall` low in T+9, so the pc advances at the end of T+9.
- Divisor zero: `stall` high in T only; `done` and results in T+1.
- The next `start` may be issued in T+9 (or T+1 for the fast paths). It is accepted with no idle gap.
- Arithmetic is unsigned.
- The partial remainder is WIDTH+1 bits wide, so the comparison never overflows.
- The counter wraps only on the terminating step; no other wrap-around is permitted.

## Configuration
- `OISC8_DIV_FASTPATH_EN` defined:
  - At acceptance, if `divisor` != 0 and `dividend` < `divisor`, skip RUN and go to DONE.
  - Result: `quotient` = 0, `remainder` = `dividend`, `done` in T+1, `stall` high in T only.
  - Also, if `divisor` == 1: `quotient` = `dividend`, `remainder` = 0, `done` in T+1.
- Not defined: every non-zero-divisor operation takes the full WIDTH RUN cycles. Results are identical either way; only latency differs.

## Test plan
- 200 / 7 -> `quotient`=28, `remainder`=4, `done` exactly in T+9, `stall` high T..T+8, `div_zero`=0.
- 255 / 1 (macro off) -> 255, 0 in T+9. With macro on -> 255, 0 in T+1.
- 5 / 0 -> `quotient`=8'hFF, `remainder`=5, `div_zero`=1, `done` in T+1. A following 9 / 3 clears `div_zero` and gives 3, 0.
- 100 / 9 started, second `start` with 50 / 5 at T+3 -> second start ignored. Result 11, 1 in T+9, no extra `done`.
- 3 / 10 -> 0, 3: in T+1 with `OISC8_DIV_FASTPATH_EN`, in T+9 without.
- 200 / 7 started, `rst` low at T+4 -> all outputs 0 immediately and FSM in IDLE. After release, 42 / 6 gives 7, 0 at the normal latency.

Source files
------------

// File: rtl/oisc8_div_ctrl.sv
// Restoring shift-subtract divide sequencer for the oisc8 DIV/MOD ports; stalls the pc while iterating.
// Optional macro OISC8_DIV_FASTPATH_EN: finish divisor==1 and dividend<divisor in one cycle.
module oisc8_div_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_rem, w_rem_nxt;
  logic [WIDTH-1:0] r_q, w_q_nxt;
  logic [WIDTH-1:0] r_d, w_d_nxt;
  logic [WIDTH-1:0] r_quot, w_quot_nxt;
  logic [WIDTH-1:0] r_remo, w_remo_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_dz, w_dz_nxt;

  logic [WIDTH:0]   w_rem_sh;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_sub;
  logic [WIDTH-1:0] w_q_sh;
  logic             w_fast;
  logic [WIDTH-1:0] w_fast_q, w_fast_r;

  // Shifted partial remainder is WIDTH+1 bits; after subtraction it is < d, so WIDTH bits hold it.
  always_comb begin
    w_rem_sh  = {r_rem, r_q[WIDTH-1]};
    w_ge      = (w_rem_sh >= {1'b0, r_d});
    w_rem_sub = w_ge ? (w_rem_sh[WIDTH-1:0] - r_d) : w_rem_sh[WIDTH-1:0];
    w_q_sh    = {r_q[WIDTH-2:0], w_ge};
  end

  always_comb begin
    w_fast   = 1'b0;
    w_fast_q = '0;
    w_fast_r = '0;
    if (divisor == '0) begin
      w_fast   = 1'b1;
      w_fast_q = '1;
      w_fast_r = dividend;
    end
`ifdef OISC8_DIV_FASTPATH_EN
    else if (divisor == WIDTH'(1)) begin
      w_fast   = 1'b1;
      w_fast_q = dividend;
      w_fast_r = '0;
    end else if (dividend < divisor) begin
      w_fast   = 1'b1;
      w_fast_q = '0;
      w_fast_r = dividend;
    end
`else
    else begin
      w_fast = 1'b0;
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    w_q_nxt     = r_q;
    w_d_nxt     = r_d;
    w_quot_nxt  = r_quot;
    w_remo_nxt  = r_remo;
    w_cnt_nxt   = r_cnt;
    w_dz_nxt    = r_dz;
    busy        = (r_state == S_RUN);
    done        = (r_state == S_DONE);
    stall       = (start && (r_state != S_RUN)) || (r_state == S_RUN);
    case (r_state)
      S_IDLE, S_DONE: begin
        w_state_nxt = S_IDLE;
        if (start) begin
          w_dz_nxt = (divisor == '0);
          if (w_fast) begin
            w_quot_nxt  = w_fast_q;
            w_remo_nxt  = w_fast_r;
            w_state_nxt = S_DONE;
          end else begin
            w_rem_nxt   = '0;
            w_q_nxt     = dividend;
            w_d_nxt     = divisor;
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        w_rem_nxt = w_rem_sub;
        w_q_nxt   = w_q_sh;
        w_cnt_nxt = r_cnt - CNT_W'(1);
        if (r_cnt == '0) begin
          w_quot_nxt  = w_q_sh;
          w_remo_nxt  = w_rem_sub;
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_quot  <= '0;
      r_remo  <= '0;
      r_cnt   <= '0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_q     <= w_q_nxt;
      r_d     <= w_d_nxt;
      r_quot  <= w_quot_nxt;
      r_remo  <= w_remo_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dz    <= w_dz_nxt;
    end
  end

  assign quotient  = r_quot;
  assign remainder = r_remo;
  assign div_zero  = r_dz;

endmodule

// File: tb/tb_oisc8_div_ctrl.sv
// Randomized and directed bench for oisc8_div_ctrl against a plain-arithmetic divide and latency model.
module tb_oisc8_div_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [7:0] divisor = 8'd0;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_zero, stall;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_q = 8'd0;
  logic [7:0] prev_r = 8'd0;

  oisc8_div_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .done(done),
    .div_zero(div_zero), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
    if (b == 8'd0) return 1;
`ifdef OISC8_DIV_FASTPATH_EN
    if (b == 8'd1 || a < b) return 1;
`else
    if (a == 8'hFF && b == 8'hFF) return 9;
`endif
    return 9;
  endfunction

  // Runs one operation. b2b: start is driven in the current (done) cycle with no idle gap.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int inj, input bit b2b);
    logic [7:0] eq, er;
    logic       edz;
    int         lat;
    edz = (b == 8'd0);
    eq  = edz ? 8'hFF : a / b;
    er  = edz ? a : a % b;
    lat = ref_lat(a, b);
    if (!b2b) begin
      @(negedge clk);
      chk("done_idle", 32'(done), 32'd0);
    end
    start = 1'b1; dividend = a; divisor = b;
    #1;
    chk("stall_T", 32'(stall), 32'd1);
    chk("busy_T", 32'(busy), 32'd0);
    @(posedge clk); #1;
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("done", 32'(done), 32'(k == lat));
      chk("stall", 32'(stall), 32'(k < lat));
      chk("busy", 32'(busy), 32'(k < lat));
      chk("div_zero", 32'(div_zero), 32'(edz));
      if (k == lat) begin
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        prev_q = eq;
        prev_r = er;
      end else begin
        chk("quot_hold", 32'(quotient), 32'(prev_q));
        chk("rem_hold", 32'(remainder), 32'(prev_r));
      end
      if (inj != 0 && k == inj) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
      end
      if (inj != 0 && k == inj + 1) start = 1'b0;
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_quot", 32'(quotient), 32'd0);
    chk("rst_rem", 32'(remainder), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    start = 1'b1; #1;
    chk("rst_stall_start", 32'(stall), 32'd1);
    start = 1'b0;
    @(negedge clk) rst = 1'b1;

    do_op(8'd200, 8'd7, 0, 1'b0);
    do_op(8'd255, 8'd1, 0, 1'b0);
    do_op(8'd5, 8'd0, 0, 1'b0);
    do_op(8'd9, 8'd3, 0, 1'b1);
    do_op(8'd100, 8'd9, 3, 1'b0);

    // Reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_quot", 32'(quotient), 32'd0);
    chk("mid_rst_rem", 32'(remainder), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_dz", 32'(div_zero), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    prev_q = 8'd0;
    prev_r = 8'd0;
    @(negedge clk);
    @(negedge clk) rst = 1'b1;
    do_op(8'd42, 8'd6, 0, 1'b0);
    do_op(8'd3, 8'd10, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0: b = 8'd0;
        1: b = 8'd1;
        2: b = 8'($urandom_range(1, 15));
        default: b = 8'($urandom);
      endcase
      do_op(a, b, 0, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    chk("final_done", 32'(done), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
